// File: rtl/vproc_pkg.sv
// vproc_pkg: shared definitions for the vproc bus-master engine.
//   - default parameter widths
//   - controller state encoding
//   - byte-enable reset/read value (used when VPROC_BYTE_ENABLE_EN is defined)
package vproc_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_IRQ_W  = 3;
  localparam int BE_W       = 4;

  // All lanes enabled: reset value and the value driven for reads.
  localparam logic [BE_W-1:0] BE_RESET = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HSHK = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/vproc_irq_latch.sv
// vproc_irq_latch: rising-edge interrupt capture with write-1-to-clear.
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   interrupt  in   level interrupt inputs
//   clear      in   write-1-to-clear mask for pending
//   pending    out  latched rising edges of interrupt
// A new edge in the same cycle as a clear of that bit wins, so no event is lost.
module vproc_irq_latch import vproc_pkg::*; #(
  parameter int IRQ_W = DEF_IRQ_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IRQ_W-1:0] interrupt,
  input  logic [IRQ_W-1:0] clear,
  output logic [IRQ_W-1:0] pending
);

  logic [IRQ_W-1:0] irq_q;

  // irq_q takes the live level in reset so a line already high is not
  // reported as an edge on the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= interrupt;
      pending <= '0;
    end else begin
      irq_q   <= interrupt;
      pending <= (pending & ~clear) | (interrupt & ~irq_q);
    end
  end

endmodule

// File: rtl/vproc_master.sv
// vproc_master: cycle-level bus master behind the co-simulation wrapper.
// Takes one read/write command at a time, drives Addr/WE/RD/DataOut, toggles
// Update and waits for the wrapper to toggle UpdateResponse, then waits for
// WRAck/RDAck and pulses RspValid with the read data.
//
// Ports:
//   Clk, Reset                          clock, synchronous active-high reset
//   CmdValid/CmdReady/CmdWrite/CmdAddr/CmdData   command port
//   RspValid/RspData                    completion pulse and read data
//   Addr/WE/RD/DataOut/DataIn/WRAck/RDAck        memory-mapped bus
//   Interrupt/IrqPending/IrqClear       edge-latched interrupt status
//   Update/UpdateResponse               wrapper toggle handshake
//   Node                                node id, debug capture only
//   CmdBE/BE                            byte enables, only with VPROC_BYTE_ENABLE_EN
//
// Optional feature macro: VPROC_BYTE_ENABLE_EN. Without it, byte lanes are
// handled by the wrapper and byte-enable writes are ordinary writes here.
module vproc_master import vproc_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IRQ_W  = DEF_IRQ_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic              CmdWrite,
  input  logic [ADDR_W-1:0] CmdAddr,
  input  logic [DATA_W-1:0] CmdData,
`ifdef VPROC_BYTE_ENABLE_EN
  input  logic [BE_W-1:0]   CmdBE,
  output logic [BE_W-1:0]   BE,
`endif
  output logic              RspValid,
  output logic [DATA_W-1:0] RspData,
  output logic [ADDR_W-1:0] Addr,
  output logic              WE,
  output logic              RD,
  output logic [DATA_W-1:0] DataOut,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              WRAck,
  input  logic              RDAck,
  input  logic [IRQ_W-1:0]  Interrupt,
  output logic [IRQ_W-1:0]  IrqPending,
  input  logic [IRQ_W-1:0]  IrqClear,
  output logic              Update,
  input  logic              UpdateResponse,
  input  logic [3:0]        Node
);

  state_t state;
  logic   resp_ref;
  logic   bus_ack;
  logic [3:0] node_unused;

  assign bus_ack = (WE && WRAck) || (RD && RDAck);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      CmdReady <= 1'b0;
      RspValid <= 1'b0;
      RspData  <= '0;
      Addr     <= '0;
      WE       <= 1'b0;
      RD       <= 1'b0;
      DataOut  <= '0;
      Update   <= 1'b0;
      resp_ref <= UpdateResponse;
`ifdef VPROC_BYTE_ENABLE_EN
      BE       <= BE_RESET;
`endif
    end else begin
      CmdReady <= 1'b0;
      RspValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CmdValid) begin
            CmdReady <= 1'b1;
            Addr     <= CmdAddr;
            DataOut  <= CmdData;
            WE       <= CmdWrite;
            RD       <= ~CmdWrite;
            // Update flips on the same edge the new strobes appear; the
            // wrapper's current response level is the reference to beat.
            Update   <= ~Update;
            resp_ref <= UpdateResponse;
`ifdef VPROC_BYTE_ENABLE_EN
            BE       <= CmdWrite ? CmdBE : BE_RESET;
`endif
            state    <= HSHK;
          end
        end
        HSHK: begin
          // Compared at the edge, so a reply given in the issue cycle is
          // taken on the first HSHK edge.
          if (UpdateResponse != resp_ref) state <= ACK;
        end
        ACK: begin
          if (bus_ack) begin
            WE       <= 1'b0;
            RD       <= 1'b0;
            RspData  <= RD ? DataIn : '0;
            RspValid <= 1'b1;
`ifdef VPROC_BYTE_ENABLE_EN
            BE       <= BE_RESET;
`endif
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Debug-only capture of the node id.
  always_ff @(posedge Clk) node_unused <= Node;

  vproc_irq_latch #(.IRQ_W(IRQ_W)) u_irq (
    .clk       (Clk),
    .reset     (Reset),
    .interrupt (Interrupt),
    .clear     (IrqClear),
    .pending   (IrqPending)
  );

endmodule

// File: tb/tb_vproc_master.sv
// Directed bench for vproc_master: write/read transactions, delayed
// handshake, interrupt latch set/clear priority, reset abort, and byte
// enables when VPROC_BYTE_ENABLE_EN is defined.
module tb_vproc_master;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CmdValid, CmdReady, CmdWrite;
  logic [31:0] CmdAddr, CmdData;
  logic        RspValid;
  logic [31:0] RspData, Addr, DataOut, DataIn;
  logic        WE, RD, WRAck, RDAck;
  logic [2:0]  Interrupt, IrqPending, IrqClear;
  logic        Update, UpdateResponse;
  logic [3:0]  Node;
`ifdef VPROC_BYTE_ENABLE_EN
  logic [3:0]  CmdBE, BE;
`endif

  // Wrapper/bus helpers: auto modes reply combinationally.
  logic wr_auto, wr_man, ur_auto, ur_man;
  assign WRAck          = wr_auto ? WE : wr_man;
  assign UpdateResponse = ur_auto ? Update : ur_man;

  int n_total = 0;
  int n_pass  = 0;

  always #5 Clk = ~Clk;

  vproc_master dut (
    .Clk(Clk), .Reset(Reset),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWrite(CmdWrite),
    .CmdAddr(CmdAddr), .CmdData(CmdData),
`ifdef VPROC_BYTE_ENABLE_EN
    .CmdBE(CmdBE), .BE(BE),
`endif
    .RspValid(RspValid), .RspData(RspData),
    .Addr(Addr), .WE(WE), .RD(RD), .DataOut(DataOut), .DataIn(DataIn),
    .WRAck(WRAck), .RDAck(RDAck),
    .Interrupt(Interrupt), .IrqPending(IrqPending), .IrqClear(IrqClear),
    .Update(Update), .UpdateResponse(UpdateResponse), .Node(Node)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; CmdValid = 1'b0; CmdWrite = 1'b0; CmdAddr = '0; CmdData = '0;
    DataIn = '0; RDAck = 1'b0; Interrupt = '0; IrqClear = '0; Node = 4'h5;
    wr_auto = 1'b0; wr_man = 1'b0; ur_auto = 1'b1; ur_man = 1'b0;
`ifdef VPROC_BYTE_ENABLE_EN
    CmdBE = 4'h0;
`endif
    tick(); tick(); tick();
    check("rst_cmdready", CmdReady, 0);
    check("rst_rspvalid", RspValid, 0);
    check("rst_rspdata", RspData, 0);
    check("rst_we_rd", {WE, RD}, 0);
    check("rst_addr", Addr, 0);
    check("rst_dataout", DataOut, 0);
    check("rst_update", Update, 0);
    check("rst_irq", IrqPending, 0);
`ifdef VPROC_BYTE_ENABLE_EN
    check("rst_be", BE, 4'hF);
`endif
    Reset = 1'b0;
    tick();

    // Write 0x1000 = DEADBEEF, immediate handshake and ack.
    wr_auto = 1'b1;
    CmdValid = 1'b1; CmdWrite = 1'b1; CmdAddr = 32'h1000; CmdData = 32'hDEADBEEF;
    tick();
    CmdValid = 1'b0;
    check("wr_cmdready", CmdReady, 1);
    check("wr_we_rd", {WE, RD}, 2'b10);
    check("wr_addr", Addr, 32'h1000);
    check("wr_dataout", DataOut, 32'hDEADBEEF);
    check("wr_update", Update, 1);
    check("wr_rsp_e0", RspValid, 0);
    tick();
    check("wr_cmdready_pulse", CmdReady, 0);
    check("wr_rsp_e1", RspValid, 0);
    check("wr_we_e1", WE, 1);
    tick();
    check("wr_rsp_e2", RspValid, 1);
    check("wr_rspdata", RspData, 0);
    check("wr_we_done", WE, 0);
    tick();
    check("wr_rsp_pulse", RspValid, 0);
    check("wr_update_once", Update, 1);

    // Read 0x2000 with RDAck held low for 4 cycles in ACK.
    wr_auto = 1'b0;
    DataIn = 32'h12345678;
    CmdValid = 1'b1; CmdWrite = 1'b0; CmdAddr = 32'h2000;
    tick();
    CmdValid = 1'b0;
    check("rd_we_rd", {WE, RD}, 2'b01);
    check("rd_update", Update, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_hold_rd", RD, 1);
      check("rd_hold_addr", Addr, 32'h2000);
      check("rd_hold_rsp", RspValid, 0);
    end
    RDAck = 1'b1;
    tick();
    RDAck = 1'b0;
    check("rd_rsp", RspValid, 1);
    check("rd_rspdata", RspData, 32'h12345678);
    check("rd_rd_done", RD, 0);
    tick();

    // Reset during the ACK phase of a read aborts it.
    DataIn = 32'hCAFEF00D;
    CmdValid = 1'b1; CmdWrite = 1'b0; CmdAddr = 32'h4000;
    tick();
    CmdValid = 1'b0;
    check("ab_rd", RD, 1);
    check("ab_update", Update, 1);
    tick();
    tick();
    check("ab_wait", RspValid, 0);
    Reset = 1'b1; RDAck = 1'b1;
    tick();
    check("ab_we_rd", {WE, RD}, 0);
    check("ab_update_rst", Update, 0);
    check("ab_rsp", RspValid, 0);
    Reset = 1'b0; RDAck = 1'b0;
    tick();
    check("ab_rsp_after", RspValid, 0);

    // Write with UpdateResponse reply delayed 5 cycles; WRAck high throughout.
    ur_auto = 1'b0; ur_man = 1'b0; wr_auto = 1'b0; wr_man = 1'b1;
    CmdValid = 1'b1; CmdWrite = 1'b1; CmdAddr = 32'h3000; CmdData = 32'hA5A5A5A5;
    tick();
    CmdValid = 1'b0;
    check("dl_we", WE, 1);
    check("dl_addr", Addr, 32'h3000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dl_hold_rsp", RspValid, 0);
      check("dl_hold_we", WE, 1);
    end
    ur_man = 1'b1;
    tick();
    check("dl_rsp_hshk", RspValid, 0);
    tick();
    check("dl_rsp", RspValid, 1);
    check("dl_rspdata", RspData, 0);
    wr_man = 1'b0;
    tick();

    // Interrupt edge latching and clear priority.
    Interrupt = 3'b001;
    tick();
    check("irq_set", IrqPending, 3'b001);
    Interrupt = 3'b000;
    tick();
    check("irq_hold", IrqPending, 3'b001);
    Interrupt = 3'b001; IrqClear = 3'b001;
    tick();
    check("irq_set_vs_clr", IrqPending, 3'b001);
    Interrupt = 3'b000; IrqClear = 3'b000;
    tick();
    check("irq_hold2", IrqPending, 3'b001);
    IrqClear = 3'b001;
    tick();
    check("irq_clr", IrqPending, 3'b000);
    IrqClear = 3'b000; Interrupt = 3'b100;
    tick();
    check("irq_set_b2", IrqPending, 3'b100);
    IrqClear = 3'b100;
    tick();
    check("irq_level_no_reset", IrqPending, 3'b000);
    IrqClear = 3'b000;
    tick();
    check("irq_level_stays_clr", IrqPending, 3'b000);
    Interrupt = 3'b000;

`ifdef VPROC_BYTE_ENABLE_EN
    ur_auto = 1'b1; wr_auto = 1'b1;
    CmdValid = 1'b1; CmdWrite = 1'b1; CmdAddr = 32'h5000; CmdBE = 4'b0011;
    tick();
    CmdValid = 1'b0;
    check("be_write", BE, 4'b0011);
    tick(); tick(); tick();
    RDAck = 1'b1;
    CmdValid = 1'b1; CmdWrite = 1'b0; CmdAddr = 32'h5004; CmdBE = 4'b0001;
    tick();
    CmdValid = 1'b0;
    check("be_read", BE, 4'hF);
    tick(); tick();
    RDAck = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
